// File: rtl/alu_op_sequencer.sv
// Sequences requests onto an external combinational ALU, including
// CMPEQ via SUB and a 32-step shift-and-add unsigned multiply.
module alu_op_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_carryout,
    output logic        rsp_zero,
    output logic        rsp_overflow,
    output logic        rsp_err,
    output logic [2:0]  alu_command,
    output logic [31:0] alu_operandA,
    output logic [31:0] alu_operandB,
    input  logic [31:0] alu_result,
    input  logic        alu_carryout,
    input  logic        alu_zero,
    input  logic        alu_overflow
);

    typedef enum logic [1:0] {IDLE, EXEC, MUL, RESP} state_t;

    localparam logic [3:0] OP_MUL   = 4'd8;
    localparam logic [3:0] OP_CMPEQ = 4'd9;

    state_t      state, state_nxt;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [31:0] acc, mcand, mplier;
    logic [4:0]  cnt;
    logic        accept;
    logic        is_mul;
    logic        is_ill;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign is_mul    = (req_op == OP_MUL);
    assign is_ill    = (req_op > OP_CMPEQ);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    unique case (1'b1)
                        is_mul:  state_nxt = MUL;
                        is_ill:  state_nxt = RESP;
                        default: state_nxt = EXEC;
                    endcase
                end
            end
            EXEC: state_nxt = RESP;
            MUL:  if (cnt == 5'd31) state_nxt = RESP;
            RESP: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ALU drive is purely a function of state; idle/resp park it at zero
    always_comb begin
        alu_command  = 3'b000;
        alu_operandA = 32'd0;
        alu_operandB = 32'd0;
        unique case (state)
            EXEC: begin
                alu_command  = (op == OP_CMPEQ) ? 3'b001 : op[2:0];
                alu_operandA = a;
                alu_operandB = b;
            end
            MUL: begin
                alu_operandA = acc;
                alu_operandB = mplier[0] ? mcand : 32'd0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op           <= 4'd0;
            a            <= 32'd0;
            b            <= 32'd0;
            acc          <= 32'd0;
            mcand        <= 32'd0;
            mplier       <= 32'd0;
            cnt          <= 5'd0;
            rsp_valid    <= 1'b0;
            rsp_result   <= 32'd0;
            rsp_carryout <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_err      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op <= req_op;
                        a  <= req_a;
                        b  <= req_b;
                        if (is_mul) begin
                            acc    <= 32'd0;
                            mcand  <= req_b;
                            mplier <= req_a;
                            cnt    <= 5'd0;
                        end
                        if (is_ill) begin
                            rsp_valid    <= 1'b1;
                            rsp_result   <= 32'd0;
                            rsp_carryout <= 1'b0;
                            rsp_zero     <= 1'b0;
                            rsp_overflow <= 1'b0;
                            rsp_err      <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    rsp_valid    <= 1'b1;
                    rsp_carryout <= alu_carryout;
                    rsp_zero     <= alu_zero;
                    rsp_overflow <= alu_overflow;
                    rsp_err      <= 1'b0;
                    if (op == OP_CMPEQ) rsp_result <= {31'd0, alu_zero};
                    else                rsp_result <= alu_result;
                end
                MUL: begin
                    acc    <= alu_result;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 5'd1;
                    // last partial sum is the product; flags are ours
                    if (cnt == 5'd31) begin
                        rsp_valid    <= 1'b1;
                        rsp_result   <= alu_result;
                        rsp_zero     <= (alu_result == 32'd0);
                        rsp_carryout <= 1'b0;
                        rsp_overflow <= 1'b0;
                        rsp_err      <= 1'b0;
                    end
                end
                RESP: if (rsp_ready) rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural external ALU.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_a, req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_carryout, rsp_zero, rsp_overflow, rsp_err;
    logic [2:0]  alu_command;
    logic [31:0] alu_operandA, alu_operandB;
    logic [31:0] alu_result;
    logic        alu_carryout, alu_zero, alu_overflow;

    typedef struct packed {
        logic [31:0] r;
        logic        c;
        logic        z;
        logic        o;
        logic        e;
    } exp_t;

    exp_t  sb[$];
    string nm_q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_carryout(rsp_carryout),
        .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow),
        .rsp_err(rsp_err), .alu_command(alu_command),
        .alu_operandA(alu_operandA), .alu_operandB(alu_operandB),
        .alu_result(alu_result), .alu_carryout(alu_carryout),
        .alu_zero(alu_zero), .alu_overflow(alu_overflow)
    );

    // external ALU: SUB is a + ~b + 1, carry is the bit-32 carry
    always_comb begin
        logic [32:0] s;
        s            = 33'd0;
        alu_result   = 32'd0;
        alu_carryout = 1'b0;
        alu_overflow = 1'b0;
        case (alu_command)
            3'b000: begin
                s = {1'b0, alu_operandA} + {1'b0, alu_operandB};
                alu_result   = s[31:0];
                alu_carryout = s[32];
                alu_overflow = (alu_operandA[31] == alu_operandB[31])
                             && (s[31] != alu_operandA[31]);
            end
            3'b001: begin
                s = {1'b0, alu_operandA} + {1'b0, ~alu_operandB} + 33'd1;
                alu_result   = s[31:0];
                alu_carryout = s[32];
                alu_overflow = (alu_operandA[31] != alu_operandB[31])
                             && (s[31] != alu_operandA[31]);
            end
            3'b010: alu_result = alu_operandA ^ alu_operandB;
            3'b011: alu_result = {31'd0,
                $signed(alu_operandA) < $signed(alu_operandB)};
            3'b100: alu_result = alu_operandA & alu_operandB;
            3'b101: alu_result = ~(alu_operandA & alu_operandB);
            3'b110: alu_result = ~(alu_operandA | alu_operandB);
            default: alu_result = alu_operandA | alu_operandB;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    task automatic chk(input string nm, input logic ok,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // monitor: every response handshake pops one expectation
    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 1'b0,
                    {32'd0, rsp_result}, 64'd0);
            end else begin
                exp_t  e;
                exp_t  act;
                string n;
                e   = sb.pop_front();
                n   = nm_q.pop_front();
                act = {rsp_result, rsp_carryout, rsp_zero,
                       rsp_overflow, rsp_err};
                chk(n, act == e, {28'd0, act}, {28'd0, e});
            end
        end
    end

    task automatic push(input string nm, input logic [31:0] r,
                        input logic c, input logic z,
                        input logic o, input logic e);
        sb.push_back({r, c, z, o, e});
        nm_q.push_back(nm);
    endtask

    task automatic issue(input string nm, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input logic c,
                         input logic z, input logic o, input logic e,
                         input int lat);
        int n;
        logic cmd_bad;
        n = 0;
        while (!req_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_ready"}, req_ready, 64'(req_ready), 64'd1);
        push(nm, r, c, z, o, e);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        cmd_bad = 1'b0;
        while (!rsp_valid && n < 100) begin
            if (alu_command != 3'b000) cmd_bad = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_latency"}, n == lat, 64'(n), 64'(lat));
        if (op == 4'd8)
            chk({nm, "_mulcmd"}, !cmd_bad, 64'(cmd_bad), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=stuck required=finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 4'd0;
        req_a     = 32'd0;
        req_b     = 32'd0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs", {rsp_valid, rsp_result, rsp_carryout,
            rsp_zero, rsp_overflow, rsp_err} == 37'd0,
            {27'd0, rsp_valid, rsp_result, rsp_carryout,
             rsp_zero, rsp_overflow, rsp_err}, 64'd0);
        chk("rst_alu", {alu_command, alu_operandA, alu_operandB} == 67'd0,
            {alu_operandA, alu_operandB}, 64'd0);
        chk("rst_ready", req_ready, 64'(req_ready), 64'd1);
        @(negedge clk);
        reset = 1'b0;

        issue("add_ovf", 4'd0, 32'h7FFFFFFF, 32'h1,
              32'h80000000, 0, 0, 1, 0, 1);
        issue("cmpeq_eq", 4'd9, 32'd5, 32'd5, 32'd1, 1, 1, 0, 0, 1);
        issue("cmpeq_ne", 4'd9, 32'd5, 32'd6, 32'd0, 0, 0, 0, 0, 1);
        issue("xor", 4'd2, 32'hFF00FF00, 32'h0F0F0F0F,
              32'hF00FF00F, 0, 0, 0, 0, 1);
        issue("slt", 4'd3, 32'hFFFFFFFF, 32'h1, 32'd1, 0, 0, 0, 0, 1);
        issue("nand", 4'd5, 32'hFFFFFFFF, 32'hFFFFFFFF,
              32'd0, 0, 1, 0, 0, 1);
        issue("nor", 4'd6, 32'd0, 32'd0, 32'hFFFFFFFF, 0, 0, 0, 0, 1);
        issue("or", 4'd7, 32'h00F0, 32'h0F00, 32'h0FF0, 0, 0, 0, 0, 1);
        issue("mul", 4'd8, 32'h00010003, 32'h7,
              32'h00070015, 0, 0, 0, 0, 32);
        issue("mul_ff", 4'd8, 32'hFFFFFFFF, 32'hFFFFFFFF,
              32'd1, 0, 0, 0, 0, 32);
        issue("mul_zero", 4'd8, 32'd0, 32'd5, 32'd0, 0, 1, 0, 0, 32);
        issue("ill_c", 4'hC, 32'd1, 32'd2, 32'd0, 0, 0, 0, 1, 0);
        issue("ill_f", 4'hF, 32'd9, 32'd9, 32'd0, 0, 0, 0, 1, 0);

        // hold the SUB response while a second request waits
        rsp_ready = 1'b0;
        push("sub_hold", 32'd0, 1, 1, 0, 0);
        req_op    = 4'd1;
        req_a     = 32'd3;
        req_b     = 32'd3;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_op = 4'd0;
        req_a  = 32'd1;
        req_b  = 32'd2;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            chk("hold_stable", {rsp_valid, rsp_result, rsp_zero,
                req_ready} == {1'b1, 32'd0, 1'b1, 1'b0},
                {29'd0, rsp_valid, rsp_result, rsp_zero, req_ready},
                {29'd0, 1'b1, 32'd0, 1'b1, 1'b0});
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        push("add_after", 32'd3, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("idle_gap", req_ready && !rsp_valid,
            {62'd0, req_ready, rsp_valid}, 64'd2);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("second_acc", !req_ready, 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        chk("second_lat", rsp_valid, 64'(rsp_valid), 64'd1);
        @(posedge clk); #1;

        // reset during MUL step 10 discards the multiply
        req_op    = 4'd8;
        req_a     = 32'h00010003;
        req_b     = 32'h7;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_rsp", {rsp_valid, rsp_result, rsp_err} == 34'd0,
            {30'd0, rsp_valid, rsp_result, rsp_err}, 64'd0);
        chk("midrst_alu", {alu_command, alu_operandA, alu_operandB}
            == 67'd0, {alu_operandA, alu_operandB}, 64'd0);
        chk("midrst_ready", req_ready, 64'(req_ready), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        issue("and_post_rst", 4'd4, 32'hF0F0F0F0, 32'hFF00FF00,
              32'hF000F000, 0, 0, 0, 0, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb.size() == 0, 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 The block SHALL expose these ports, with registered outputs unless noted:
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  combinational; high only in IDLE
- req_op  in  4  0-7 = direct ALU command (ADD 000, SUB 001, XOR 010, SLT 011, AND 100, NAND 101, NOR 110, OR 111); 8 = MUL; 9 = CMPEQ; 10-15 illegal
- req_a, req_b  in  32  operands
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_result  out  32  result word
- rsp_carryout, rsp_zero, rsp_overflow  out  1 each  flags
- rsp_err  out  1  illegal opcode flag
- alu_command  out  3  command to external ALU, combinational from state
- alu_operandA, alu_operandB  out  32 each  operands to external ALU, combinational from state
- alu_result  in  32  external ALU result
- alu_carryout, alu_zero, alu_overflow  in  1 each  external ALU flags; the ALU is purely combinational

Function
REQ-002 The FSM SHALL have exactly four states: IDLE, EXEC, MUL, RESP.
REQ-003 In IDLE, a transfer occurs when req_valid and req_ready are both high at a rising edge; the block SHALL latch op, a and b on that edge.
REQ-004 On acceptance, op 0-7 or 9 SHALL go to EXEC, op 8 SHALL go to MUL with acc=0, mcand=b, mplier=a, cnt=0, and op 10-15 SHALL go directly to RESP with result 0, all flags 0, and rsp_err=1.
REQ-005 In EXEC, the block SHALL drive alu_command=op[2:0] (SUB 001 for CMPEQ) with alu_operandA=a and alu_operandB=b.
REQ-006 On the edge leaving EXEC, the block SHALL capture alu_result and all three flags into rsp_* and move to RESP.
REQ-007 For CMPEQ, rsp_result SHALL be {31'b0, alu_zero}, rsp_zero SHALL be alu_zero, and carryout/overflow SHALL be as captured.
REQ-008 In MUL, each cycle SHALL drive alu_command=000, alu_operandA=acc, and alu_operandB = mplier[0] ? mcand : 0.
REQ-009 At each MUL edge: acc<=alu_result, mcand<=mcand<<1, mplier<=mplier>>1, cnt<=cnt+1.
REQ-010 After the step with cnt==31 (32 steps total), the block SHALL go to RESP.
REQ-011 The MUL response SHALL be rsp_result = low 32 bits of the unsigned product, rsp_zero = (product low 32 == 0), and rsp_carryout = rsp_overflow = 0.
REQ-012 In IDLE and RESP, alu_command SHALL be 000 and both ALU operands SHALL be 0.
REQ-013 Response latency, with acceptance at edge k, SHALL be: rsp_valid high after edge k+1 for op 0-7/9, after edge k+32 for MUL, and after edge k for illegal ops.
REQ-014 In RESP, rsp_valid SHALL be 1, and rsp_* SHALL hold stable until the edge where rsp_ready=1; that edge SHALL return to IDLE with rsp_valid=0.
REQ-015 The block SHALL accept no new request in EXEC, MUL or RESP; req_valid there SHALL be ignored, and back-to-back issue SHALL take at least one IDLE cycle.
REQ-016 rsp_err SHALL be 0 for every legal op.
REQ-017 Multiplication SHALL be unsigned and modulo 2^32, with no early termination.

Reset
REQ-018 While reset is high, asynchronously: state=IDLE, rsp_valid=0, rsp_result=0, all rsp flags=0, rsp_err=0, acc/mcand/mplier/cnt=0, alu_command=000, ALU operands=0.
REQ-019 Reset mid-operation (EXEC/MUL/RESP) SHALL discard the operation with no response, and the first edge after release SHALL be able to accept a new request.

Verification
REQ-020 ADD a=0x7FFFFFFF, b=0x00000001 -> after edge k+1: rsp_result=0x80000000, overflow=1, carryout=0, zero=0, err=0.
REQ-021 CMPEQ 5,5 -> rsp_result=1, zero=1; CMPEQ 5,6 -> rsp_result=0, zero=0.
REQ-022 MUL a=0x00010003, b=0x00000007 -> rsp_result=0x00070015, rsp_valid first high after edge k+32, alu_command=000 throughout; MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001.
REQ-023 SUB 3,3 then hold rsp_ready=0 for 5 cycles with req_valid=1 -> rsp_result=0 and zero=1 stable, req_ready=0, second request not accepted until after the rsp_ready handshake.
REQ-024 Reset pulse during MUL step 10 -> all outputs reset immediately, no response; then AND 0xF0F0F0F0, 0xFF00FF00 -> 0xF000F000.
REQ-025 req_op=0xC -> rsp_valid after edge k, rsp_err=1, rsp_result=0, all flags 0.
